// File: rtl/ysyx_25040111_rfctl.sv
// Register-file write-port arbiter (round-robin EXU/LSU) and RAW/WAW scoreboard for RV32E.
// Optional performance counters are enabled with `define YSYX_25040111_RFCTL_PERF_EN.
module ysyx_25040111_rfctl (
    input  logic        clock,
    input  logic        reset_n,
    input  logic        iss_valid,
    input  logic [1:0]  iss_ren,
    input  logic [3:0]  iss_rs1,
    input  logic [3:0]  iss_rs2,
    input  logic [3:0]  iss_rd,
    input  logic        iss_wr,
    output logic        iss_ready,
    input  logic        exu_valid,
    output logic        exu_ready,
    input  logic [3:0]  exu_waddr,
    input  logic [31:0] exu_wdata,
    input  logic        lsu_valid,
    output logic        lsu_ready,
    input  logic [3:0]  lsu_waddr,
    input  logic [31:0] lsu_wdata,
    input  logic        flush,
    output logic        rf_wen,
    output logic [3:0]  rf_waddr,
    output logic [31:0] rf_wdata,
    output logic [1:0]  rf_ren,
    output logic        err,
    output logic [31:0] perf_stall,
    output logic [31:0] perf_conflict
);

    logic [15:0] busy_reg;
    logic [15:0] busy_next;
    logic [15:0] clr_vec;
    logic [15:0] set_vec;
    logic [15:0] busy_eff;
    logic        rr_reg;
    logic        flush_d_reg;
    logic        err_reg;
    logic        exu_gnt;
    logic        lsu_gnt;
    logic        gnt_any;
    logic [3:0]  gnt_addr;
    logic [31:0] gnt_data;
    logic        raw_hit;
    logic        waw_hit;
    logic        iss_fire;
    logic        err_hit;

    // Grants are suppressed while reset is held so nothing reaches the register file.
    always_comb begin
        exu_gnt  = reset_n & exu_valid & (~lsu_valid | ~rr_reg);
        lsu_gnt  = reset_n & lsu_valid & (~exu_valid | rr_reg);
        gnt_any  = exu_gnt | lsu_gnt;
        gnt_addr = 4'd0;
        gnt_data = 32'd0;
        if (exu_gnt) begin
            gnt_addr = exu_waddr;
            gnt_data = exu_wdata;
        end else if (lsu_gnt) begin
            gnt_addr = lsu_waddr;
            gnt_data = lsu_wdata;
        end
    end

    assign exu_ready = exu_gnt;
    assign lsu_ready = lsu_gnt;
    assign rf_wen    = gnt_any & (gnt_addr != 4'd0);
    assign rf_waddr  = gnt_addr;
    assign rf_wdata  = gnt_data;
    assign rf_ren    = iss_ren & {2{iss_valid & reset_n}};

    genvar gi;
    generate
        for (gi = 0; gi < 16; gi++) begin : g_sb
            assign clr_vec[gi]  = gnt_any & (gnt_addr == 4'(gi));
            assign set_vec[gi]  = iss_fire & iss_wr & (iss_rd == 4'(gi));
            assign busy_eff[gi] = busy_reg[gi] & ~clr_vec[gi];
        end
    endgenerate

    // A same-cycle writeback releases its register; the register file forwards wdata.
    assign raw_hit   = (iss_ren[0] & busy_eff[iss_rs1]) | (iss_ren[1] & busy_eff[iss_rs2]);
    assign waw_hit   = iss_wr & busy_eff[iss_rd];
    assign iss_ready = ~reset_n | (~flush & ~raw_hit & ~waw_hit);
    assign iss_fire  = iss_valid & iss_ready & reset_n;

    always_comb begin
        if (flush) begin
            busy_next = 16'd0;
        end else begin
            busy_next = (busy_reg & ~clr_vec) | set_vec;
        end
        busy_next[0] = 1'b0;
    end

    assign err_hit = gnt_any & (gnt_addr != 4'd0) & ~busy_reg[gnt_addr] & ~flush & ~flush_d_reg;

    always_ff @(posedge clock or negedge reset_n) begin
        if (!reset_n) begin
            busy_reg    <= 16'd0;
            rr_reg      <= 1'b0;
            flush_d_reg <= 1'b0;
            err_reg     <= 1'b0;
        end else begin
            busy_reg    <= busy_next;
            flush_d_reg <= flush;
            if (exu_valid & lsu_valid) begin
                rr_reg <= ~rr_reg;
            end
            if (err_hit) begin
                err_reg <= 1'b1;
            end
        end
    end

    assign err = err_reg;

`ifdef YSYX_25040111_RFCTL_PERF_EN
    logic [31:0] stall_cnt_reg;
    logic [31:0] conflict_cnt_reg;

    always_ff @(posedge clock or negedge reset_n) begin
        if (!reset_n) begin
            stall_cnt_reg    <= 32'd0;
            conflict_cnt_reg <= 32'd0;
        end else begin
            if (iss_valid & ~iss_ready & ~flush) begin
                stall_cnt_reg <= stall_cnt_reg + 32'd1;
            end
            if (exu_valid & lsu_valid) begin
                conflict_cnt_reg <= conflict_cnt_reg + 32'd1;
            end
        end
    end

    assign perf_stall    = stall_cnt_reg;
    assign perf_conflict = conflict_cnt_reg;
`else
    assign perf_stall    = 32'd0;
    assign perf_conflict = 32'd0;
`endif

endmodule

// File: doc/ysyx_25040111_rfctl.md
# ysyx_25040111_rfctl

Register-file write-port arbiter and scoreboard for the 16-entry RV32E register file. Shares the single register-file write port between the EXU and LSU writeback paths using round-robin arbitration. Tracks pending destination registers so that decode/issue stalls on RAW and WAW hazards. Sits between issue, the two writeback sources and the register file's `wen/waddr/wdata/ren` inputs.

## Interface

- No parameters. Register count is fixed at 16 and data width at 32.
- `clock` in 1: single clock, rising edge.
- `reset_n` in 1: asynchronous, active-low reset.
- `iss_valid` in 1: issue request from decode.
- `iss_ren` in 2: bit0 means rs1 is used, bit1 means rs2 is used.
- `iss_rs1`, `iss_rs2`, `iss_rd` in 4 each: source and destination indices.
- `iss_wr` in 1: the instruction writes `iss_rd`.
- `iss_ready` out 1: no hazard; the issue fires when `iss_valid & iss_ready`.
- `exu_valid`/`lsu_valid` in 1, `exu_ready`/`lsu_ready` out 1: writeback handshakes.
- `exu_waddr`/`lsu_waddr` in 4, `exu_wdata`/`lsu_wdata` in 32: writeback payloads.
- `flush` in 1: discard all pending-write tracking.
- `rf_wen` out 1, `rf_waddr` out 4, `rf_wdata` out 32: register-file write port.
- `rf_ren` out 2: equals `iss_ren` gated by `iss_valid`.
- `err` out 1: sticky flag set by a writeback to a register that is not busy.
- `perf_stall` out 32, `perf_conflict` out 32: performance counters (see Configuration).

## Operation

- **Scoreboard:** `busy[15:0]`. Bit 0 is hardwired to 0.
- **Writeback arbitration:**
  - At most one writeback is granted per cycle.
  - Only one source valid: that source is granted.
  - Both sources valid: the source named by the round-robin pointer `rr` is granted. `rr`=0 means EXU.
  - After a two-way conflict, `rr` toggles to favour the loser.
  - A single-source grant leaves `rr` unchanged.
- **Ready outputs:** `exu_ready`/`lsu_ready` equal that source's grant. They are combinational and do not depend on `rf_*`.
- **Granted write:** `rf_wen`=1, `rf_waddr`/`rf_wdata` come from the winner, and `busy[waddr]` clears at the next edge.
- **Write to x0:** granted normally, but `rf_wen` is forced to 0.
- **No grant:** `rf_wen`=0, and `rf_waddr`/`rf_wdata` are 0.
- **Hazard check:** `iss_ready` = no RAW & no WAW.
  - RAW: (`iss_ren[0]` & `busy_eff[rs1]`) | (`iss_ren[1]` & `busy_eff[rs2]`).
  - WAW: `iss_wr` & `busy_eff[rd]`.
  - `busy_eff[i]` = `busy[i]` & ~(a granted writeback to i in the same cycle).
  - Same-cycle release is legal because the register file forwards `wdata` on a write-address match.
- **Issue fire** with `iss_wr` and `rd`≠0 sets `busy[rd]` at the next edge.
- **Set vs clear on the same register in the same cycle:** set wins, because the new owner takes the register.
- **Flush:**
  - All busy bits clear at the next edge; a set in the same cycle is also discarded.
  - `iss_ready` is forced to 0 during `flush`.
  - A grant in the flush cycle still writes the register file and does not set `err`.
- **err:** set when a granted writeback has `waddr`≠0 and `busy[waddr]`=0, outside a flush cycle and outside the cycle after a flush. Cleared only by reset.

## Timing

- Reset state: `busy`=0, `rr`=0, `err`=0, counters=0.
- Outputs while `reset_n`=0: `iss_ready`=1 when `iss_valid`=0; all `rf_*` = 0; both writeback readies = 0.
- Reset is asserted asynchronously. Deassertion is assumed synchronous to `clock` by the upstream reset synchroniser.
- All outputs except the registered state (`busy`, `rr`, `err`, counters) are combinational, with zero latency from their inputs.
- Scoreboard updates become visible one cycle after the handshake edge.
- Back-to-back example: issue writes x5 in cycle N; EXU writeback to x5 in cycle N+1; an instruction reading x5 may issue in cycle N+1 (forwarded).
- Reset mid-operation: the scoreboard and arbitration state are lost immediately. Writebacks still in flight upstream are the producer's responsibility; after reset they raise `err` if they arrive.

## Configuration

- Macro: `YSYX_25040111_RFCTL_PERF_EN`.
- **Defined:**
  - `perf_stall` increments (wrapping at 2^32) every cycle with `iss_valid` & ~`iss_ready` & ~`flush`.
  - `perf_conflict` increments every cycle in which both writeback sources are valid.
- **Undefined:** both ports are tied to 32'd0 and no counter flops are synthesised.

## Test plan

- **Reset and idle:** assert `reset_n`=0 mid-run with busy bits set → `busy`=0, `err`=0, `rf_wen`=0. After release, issue `rs1`=3 with `ren`=01 → `iss_ready`=1.
- **RAW stall and release:** issue `rd`=5 (`iss_wr`=1); next cycle issue `rs2`=5 with `ren`=10 → `iss_ready`=0. The cycle EXU writes x5=32'hDEADBEEF → `iss_ready`=1, `rf_wen`=1, `rf_waddr`=5.
- **Arbitration:** EXU and LSU valid for 4 consecutive cycles with distinct busy registers → grant order EXU, LSU, EXU, LSU. With the perf macro defined, `perf_conflict`=4.
- **WAW and x0:**
  - Issue `rd`=0 → no busy bit set. LSU write to x0 → `rf_wen`=0 and `lsu_ready`=1.
  - Issue `rd`=7 twice → the second issue stalls until x7 is written back.
- **Set/clear same cycle:** x9 busy, EXU writes x9 while a new issue with `rd`=9 fires → `busy[9]`=1 afterwards and `err`=0.
- **Flush and err:** set busy x2 and x4, pulse `flush` → busy clears and `iss_ready`=0 during the flush cycle. An LSU write to x4 two cycles later → `err`=1, and it stays 1 until reset.
